ram_bank: RTL and testbench
===========================

# ram_bank

Parametrised word-addressable RAM built as the successor to the single-bit load register: `2**ADDR_W` words of `WIDTH` bits, written on `load` and read at `address`. Includes a hardware clear sequencer that zeroes every word after reset or on request. It is the data-memory and register-file building block for the CPU and memory layers of the hardware platform.

## Interface

**Parameters**
- `WIDTH`, 16: data word width in bits (≥1).
- `ADDR_W`, 3: address width. `DEPTH = 2**ADDR_W` words (≥1 bit).

**Ports**
- `CLK` in, 1 bit: single clock; all state updates on the rising edge.
- `RST` in, 1 bit: reset, asynchronous and active-high.
- `D` in, `WIDTH` bits: write data.
- `address` in, `ADDR_W` bits: read/write word select.
- `load` in, 1 bit: write enable.
- `clear` in, 1 bit: start a zeroing sweep of all words.
- `Q` out, `WIDTH` bits: read data.
- `busy` out, 1 bit: clear sweep in progress; writes are blocked.

## Operation

- **Storage:** `DEPTH` × `WIDTH` array. The array is not reset asynchronously; it is zeroed by the sweep.
- **FSM states:** IDLE, CLEAR. Sweep pointer `ptr` is `ADDR_W` bits wide.
- **`RST` asserted:**
  - Immediately: state=CLEAR, `ptr`=0, `busy`=1, `Q`=0.
  - This applies at any point, including mid-sweep. The sweep restarts from word 0.
- **CLEAR:**
  - Each edge writes 0 to `mem[ptr]` and increments `ptr`.
  - On the edge that writes word `DEPTH-1`: state→IDLE, `ptr`→0.
  - `load` and `clear` are ignored.
  - `Q` is held at 0.
- **IDLE:**
  - `clear`=1: state→CLEAR and `ptr`=0 on that edge. No word is written on that edge.
  - `load`=1 (and `clear`=0): `mem[address]` ← `D` on the edge.
  - `clear` and `load` in the same cycle: clear wins, and the write is dropped.
- **Read path:** `Q` = `mem[address]` (see Configuration for latency).
- **`busy`** = 1 exactly when state=CLEAR.
- **Width rules:**
  - `address` is always in range, since `DEPTH = 2**ADDR_W`.
  - `ptr` wraps naturally from `DEPTH-1` to 0.
  - No truncation or extension of `D`.

## Timing

- **Sweep length:** `DEPTH` rising edges after `RST` deasserts, or after the edge that samples `clear`. `busy` falls after the last of those edges.
- **Minimum sweep:** `DEPTH`=2 gives 2 cycles busy.
- **Write latency:** 1 edge. The new value is visible on `Q` for the same `address` right after the edge (combinational read).
- **`load` held high:** writes `D` on every edge. This matches the single-bit register semantics: `Q(t+1) = load ? D(t) : Q(t)`.
- **`clear` while busy:** has no effect. It does not extend or restart the sweep.

## Configuration

- **Macro:** `RAM_BANK_READ_REG_EN`.
- **Undefined:**
  - `Q` is combinational from `mem[address]`, with 0 read latency.
  - Forced to 0 while `busy`.
- **Defined:**
  - `Q` is registered and updates on each edge, giving 1 cycle of read latency.
  - Reset value is 0.
  - Read-during-write to the same address is write-first: `Q` ← `D`.
  - While `busy`, `Q` ← 0.
  - On the edge that leaves CLEAR, `Q` loads `mem[address]`, which is 0.

## Test plan

- **Reset sweep:** `WIDTH`=16, `ADDR_W`=3; assert `RST`, release → `busy`=1 for exactly 8 edges then 0. Reading all 8 addresses returns 0x0000.
- **Write/hold:**
  - Write 0xBEEF to addr 5 with `load`=1 for one edge, then `load`=0 for 3 edges → `Q`=0xBEEF at addr 5 throughout.
  - Addr 4 reads 0x0000.
- **Blocked write:**
  - Pulse `clear`, then assert `load`=1, addr 2, `D`=0x1234 during the sweep → after `busy` falls, addr 2 reads 0x0000.
  - The 8-cycle sweep length is unchanged.
- **Simultaneous clear+load in IDLE:** addr 1 = 0x00FF; in the same cycle apply `clear`=1, `load`=1, `D`=0xAAAA → `busy` rises, and after the sweep addr 1 reads 0x0000.
- **Reset mid-sweep:** assert `RST` at sweep cycle 4 → `busy` stays 1; after release a full 8-edge sweep follows; all words read 0.
- **With `RAM_BANK_READ_REG_EN`:** write 0x0F0F to addr 3 while `address`=3 → `Q`=0x0F0F on that same edge (write-first). Switching `address` to 6 → `Q`=0x0000 one edge later.

Source files
------------

// File: rtl/ram_bank.sv
// Word-addressable RAM with a hardware zeroing sweep after reset or on clear.
// Optional registered read port: define RAM_BANK_READ_REG_EN.
module ram_bank #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  Q,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  ptr, ptr_nx;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic [WIDTH-1:0]   wdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      CLEAR: begin
        ptr_nx = ptr + 1'b1;
        if (ptr == '1) state_nx = IDLE;
      end
      default: state_nx = CLEAR;
    endcase
  end

  // The sweep borrows the single write port; user writes are blocked meanwhile.
  always_comb begin
    busy  = (state == CLEAR);
    we    = busy | (load & ~clear);
    waddr = busy ? ptr : address;
    wdata = busy ? '0 : D;
  end

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef RAM_BANK_READ_REG_EN
  // Forwarding the write port also covers the last sweep edge, when word DEPTH-1 is still stale.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      Q <= '0;
    else if (state_nx == CLEAR)
      Q <= '0;
    else if (we && (waddr == address))
      Q <= wdata;
    else
      Q <= mem[address];
  end
`else
  always_comb begin
    Q = busy ? '0 : mem[address];
  end
`endif

endmodule

// File: tb/tb_ram_bank.sv
// Self-checking bench for ram_bank: array-level reference model plus directed vectors.
`timescale 1ns/1ps
module tb_ram_bank;

  localparam int W  = 16;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [W-1:0]  D = '0;
  logic [AW-1:0] address = '0;
  logic          load = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  Q;
  logic          busy;

  int compared = 0;
  int mismatched = 0;

  ram_bank #(.WIDTH(W), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .D(D), .address(address),
    .load(load), .clear(clear), .Q(Q), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: words still to be zeroed, memory contents, registered-read value.
  int           sweep_left = N;
  logic [W-1:0] mm [N];
  logic [W-1:0] mq = '0;

  always @(posedge CLK) begin
    if (RST) begin
      sweep_left = N;
    end else if (sweep_left > 0) begin
      mm[N - sweep_left] = '0;
      sweep_left--;
    end else if (clear) begin
      sweep_left = N;
    end else if (load) begin
      mm[address] = D;
    end
    mq = (sweep_left > 0) ? '0 : mm[address];
  end

  always @(posedge RST) begin
    sweep_left = N;
    mq = '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_q();
`ifdef RAM_BANK_READ_REG_EN
    return mq;
`else
    return (sweep_left > 0) ? '0 : mm[address];
`endif
  endfunction

  always @(posedge CLK) begin
    #1;
    check("model_busy", {31'd0, busy}, {31'd0, sweep_left > 0});
    check("model_q", {16'd0, Q}, {16'd0, exp_q()});
  end

  task automatic cycle(input logic r, input logic ld, input logic clr,
                       input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge CLK);
    RST = r; load = ld; clear = clr; address = a; D = d;
    @(posedge CLK);
    #2;
  endtask

  // Runs edges until busy drops (bounded); first edge is the one the caller sets up.
  task automatic sweep(input string name, input logic ld, input logic [AW-1:0] a,
                       input logic [W-1:0] d);
    int n = 0;
    do begin
      cycle(1'b0, ld, 1'b0, a, d);
      n++;
    end while (busy && n < 20);
    check(name, n, 32'd8);
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 1'b0, 1'b0, AW'(i), 16'hFFFF);
      check(name, {16'd0, Q}, 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge CLK);
    #2;
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_q", {16'd0, Q}, 32'h0);
    sweep("reset_sweep_len", 1'b0, 3'd0, 16'h0);
    check("post_sweep_busy", {31'd0, busy}, 32'd0);
    read_all_zero("reset_read0");

    cycle(1'b0, 1'b1, 1'b0, 3'd5, 16'hBEEF);
    check("write_a5", {16'd0, Q}, 32'hBEEF);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'd5, 16'h1111);
      check("hold_a5", {16'd0, Q}, 32'hBEEF);
    end
    cycle(1'b0, 1'b0, 1'b0, 3'd4, 16'h0);
    check("read_a4", {16'd0, Q}, 32'h0);

    cycle(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
    check("clear_busy", {31'd0, busy}, 32'd1);
    sweep("blocked_sweep_len", 1'b1, 3'd2, 16'h1234);
    cycle(1'b0, 1'b0, 1'b0, 3'd2, 16'h0);
    check("blocked_a2", {16'd0, Q}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 3'd5, 16'h0);
    check("cleared_a5", {16'd0, Q}, 32'h0);

    cycle(1'b0, 1'b1, 1'b0, 3'd1, 16'h00FF);
    check("write_a1", {16'd0, Q}, 32'h00FF);
    cycle(1'b0, 1'b1, 1'b1, 3'd1, 16'hAAAA);
    check("clr_ld_busy", {31'd0, busy}, 32'd1);
    check("clr_ld_q", {16'd0, Q}, 32'h0);
    sweep("clr_ld_sweep_len", 1'b0, 3'd1, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 3'd1, 16'h0);
    check("clr_ld_a1", {16'd0, Q}, 32'h0);

    cycle(1'b0, 1'b1, 1'b0, 3'd7, 16'h5555);
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 16'h3C3C);
    check("write_a0", {16'd0, Q}, 32'h3C3C);
    cycle(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 3'd7, 16'h0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    check("midrst_q", {16'd0, Q}, 32'h0);
    @(posedge CLK);
    #2;
    sweep("midrst_sweep_len", 1'b0, 3'd7, 16'h0);
    read_all_zero("midrst_read0");

    cycle(1'b0, 1'b1, 1'b0, 3'd3, 16'h0F0F);
    check("wf_a3", {16'd0, Q}, 32'h0F0F);
    cycle(1'b0, 1'b0, 1'b0, 3'd6, 16'h0);
    check("rd_a6", {16'd0, Q}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 3'd3, 16'h0);
    check("rd_a3", {16'd0, Q}, 32'h0F0F);

    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
